// File: rtl/wb_vmemem_pkg.sv
// -----------------------------------------------------------------------------
// wb_vmemem_pkg
// Shared types and constants for the Wishbone to VME memory-style bank bridge.
//   state_t        : bridge FSM states (IDLE, WAIT, RESP)
//   WB_SEL_FULL    : byte-select pattern of a full 32-bit access
//   EVT_CNT_W      : width of the saturating timeout event counter
//   tmo_ctr_width  : bits needed to hold the value TIMEOUT (clog2(TIMEOUT+1))
// -----------------------------------------------------------------------------
package wb_vmemem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [3:0] WB_SEL_FULL = 4'hF;
    localparam int         EVT_CNT_W   = 8;

    // Smallest w with 2**w >= timeout+1, so the counter can be loaded with
    // the value TIMEOUT itself.
    function automatic int tmo_ctr_width(input int timeout);
        int w;
        w = 1;
        while ((1 << w) < (timeout + 1)) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/bridge_timeout_ctr.sv
// -----------------------------------------------------------------------------
// bridge_timeout_ctr
// Per-access wait counter plus a saturating count of timeout events.
//   clk, rst_n      : clock, synchronous active-low reset
//   i_load          : load the wait counter with TIMEOUT
//   i_dec           : decrement the wait counter (holds at zero)
//   i_event         : one timeout happened; bump the event counter
//   o_zero          : wait counter is zero
//   o_event_count   : timeouts since reset, saturating at 255
// -----------------------------------------------------------------------------
module bridge_timeout_ctr
    import wb_vmemem_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_load,
    input  logic                 i_dec,
    input  logic                 i_event,
    output logic                 o_zero,
    output logic [EVT_CNT_W-1:0] o_event_count
);

    localparam int CNT_W = tmo_ctr_width(TIMEOUT);

    logic [CNT_W-1:0]     r_cnt;
    logic [EVT_CNT_W-1:0] r_evt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= CNT_W'(TIMEOUT);
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_evt <= '0;
        end else if (i_event && (r_evt != {EVT_CNT_W{1'b1}})) begin
            r_evt <= r_evt + 1'b1;
        end
    end

    assign o_zero        = (r_cnt == '0);
    assign o_event_count = r_evt;

endmodule

// File: rtl/wb_vmemem_bridge.sv
// -----------------------------------------------------------------------------
// wb_vmemem_bridge
// Wishbone classic single-cycle slave that drives a generated register bank
// through its VME memory-style interface. Each Wishbone access becomes a
// one-cycle rd/wr strobe; the bridge then waits for the bank's done/error of
// the same direction, or gives up after TIMEOUT idle WAIT cycles.
//
// Ports
//   clk, rst_n              : clock, synchronous active-low reset
//   wb_cyc_i/stb_i/we_i     : Wishbone cycle, strobe, write enable
//   wb_adr_i                : byte address, bits [1:0] ignored
//   wb_sel_i, wb_dat_i      : byte selects (only 4'hF writes allowed), data
//   wb_dat_o, wb_ack_o      : read data (valid with ack), completion pulse
//   wb_err_o                : error pulse (partial write, bank error, timeout)
//   mem_addr_o              : latched word address
//   mem_wr_data_o           : latched write data
//   mem_rd_o, mem_wr_o      : one-cycle access strobes
//   mem_rd_data_i           : bank read data, taken with mem_rd_done_i
//   mem_rd/wr_done_i        : bank completion
//   mem_rd/wr_error_i       : bank error
//   timeout_o               : one-cycle pulse per timeout
//   timeout_count_o         : saturating timeout count since reset
//   dbg_state_o             : current FSM state
//
// Handshake: a request is a cycle with wb_cyc_i & wb_stb_i while IDLE. The
// answer is a single registered ack or err pulse, emitted only if wb_cyc_i is
// still high when the bank answers; a dropped cycle lets the bank transaction
// run to completion silently.
// -----------------------------------------------------------------------------
module wb_vmemem_bridge
    import wb_vmemem_pkg::*;
#(
    parameter int ADDR_WIDTH = 18,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wb_cyc_i,
    input  logic                  wb_stb_i,
    input  logic                  wb_we_i,
    input  logic [ADDR_WIDTH+1:0] wb_adr_i,
    input  logic [3:0]            wb_sel_i,
    input  logic [31:0]           wb_dat_i,
    output logic [31:0]           wb_dat_o,
    output logic                  wb_ack_o,
    output logic                  wb_err_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [31:0]           mem_wr_data_o,
    output logic                  mem_rd_o,
    output logic                  mem_wr_o,
    input  logic [31:0]           mem_rd_data_i,
    input  logic                  mem_rd_done_i,
    input  logic                  mem_wr_done_i,
    input  logic                  mem_rd_error_i,
    input  logic                  mem_wr_error_i,
    output logic                  timeout_o,
    output logic [EVT_CNT_W-1:0]  timeout_count_o,
    output state_t                dbg_state_o
);

    state_t                r_state,  w_state_next;
    logic [ADDR_WIDTH-1:0] r_addr,   w_addr_next;
    logic [31:0]           r_wdata,  w_wdata_next;
    logic                  r_we,     w_we_next;
    logic                  r_mem_rd, w_mem_rd_next;
    logic                  r_mem_wr, w_mem_wr_next;
    logic                  r_ack,    w_ack_next;
    logic                  r_err,    w_err_next;
    logic [31:0]           r_dat,    w_dat_next;
    logic                  r_tmo,    w_tmo_next;

    logic                  w_load;
    logic                  w_dec;
    logic                  w_event;
    logic                  w_zero;
    logic                  w_done;
    logic                  w_error;
    logic                  w_req;
    logic [EVT_CNT_W-1:0]  w_evt_count;
    logic                  w_unused_adr_lsb;

    // Byte lane bits of the address carry no information for word banks.
    assign w_unused_adr_lsb = ^wb_adr_i[1:0];

    assign w_req = wb_cyc_i & wb_stb_i;

    // Only the direction of the access in flight is listened to.
    assign w_done  = r_we ? mem_wr_done_i  : mem_rd_done_i;
    assign w_error = r_we ? mem_wr_error_i : mem_rd_error_i;

    bridge_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_tmo (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_load        (w_load),
        .i_dec         (w_dec),
        .i_event       (w_event),
        .o_zero        (w_zero),
        .o_event_count (w_evt_count)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_we     <= 1'b0;
            r_mem_rd <= 1'b0;
            r_mem_wr <= 1'b0;
            r_ack    <= 1'b0;
            r_err    <= 1'b0;
            r_dat    <= '0;
            r_tmo    <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_addr   <= w_addr_next;
            r_wdata  <= w_wdata_next;
            r_we     <= w_we_next;
            r_mem_rd <= w_mem_rd_next;
            r_mem_wr <= w_mem_wr_next;
            r_ack    <= w_ack_next;
            r_err    <= w_err_next;
            r_dat    <= w_dat_next;
            r_tmo    <= w_tmo_next;
        end
    end

    // Next-state and next-output logic. Every output is a register, so each
    // pulse computed here appears one cycle after its cause.
    always_comb begin
        w_state_next  = r_state;
        w_addr_next   = r_addr;
        w_wdata_next  = r_wdata;
        w_we_next     = r_we;
        w_mem_rd_next = 1'b0;
        w_mem_wr_next = 1'b0;
        w_ack_next    = 1'b0;
        w_err_next    = 1'b0;
        w_dat_next    = '0;
        w_tmo_next    = 1'b0;
        w_load        = 1'b0;
        w_dec         = 1'b0;
        w_event       = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_req) begin
                    w_addr_next  = wb_adr_i[ADDR_WIDTH+1:2];
                    w_wdata_next = wb_dat_i;
                    w_we_next    = wb_we_i;
                    if (wb_we_i && (wb_sel_i != WB_SEL_FULL)) begin
                        // Banks only take full words: refuse without
                        // touching the bank.
                        w_state_next = RESP;
                        w_err_next   = 1'b1;
                    end else begin
                        w_state_next  = WAIT;
                        w_mem_rd_next = ~wb_we_i;
                        w_mem_wr_next = wb_we_i;
                        w_load        = 1'b1;
                    end
                end
            end

            WAIT: begin
                // Priority: done, then error, then timeout.
                if (w_done) begin
                    w_state_next = RESP;
                    w_ack_next   = wb_cyc_i;
                    w_dat_next   = (!r_we && wb_cyc_i) ? mem_rd_data_i : '0;
                end else if (w_error) begin
                    w_state_next = RESP;
                    w_err_next   = wb_cyc_i;
                end else if (w_zero) begin
                    w_state_next = RESP;
                    w_err_next   = wb_cyc_i;
                    w_tmo_next   = 1'b1;
                    w_event      = 1'b1;
                end else begin
                    w_dec = 1'b1;
                end
            end

            RESP: begin
                w_state_next = IDLE;
            end

            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    assign wb_dat_o        = r_dat;
    assign wb_ack_o        = r_ack;
    assign wb_err_o        = r_err;
    assign mem_addr_o      = r_addr;
    assign mem_wr_data_o   = r_wdata;
    assign mem_rd_o        = r_mem_rd;
    assign mem_wr_o        = r_mem_wr;
    assign timeout_o       = r_tmo;
    assign timeout_count_o = w_evt_count;
    assign dbg_state_o     = r_state;

endmodule

// File: tb/tb_wb_vmemem_bridge.sv
module tb_wb_vmemem_bridge;
  import wb_vmemem_pkg::*;

  localparam int AW  = 18;
  localparam int TMO = 4;

  // ---------------------------------------------------------------- clock/reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          wb_cyc_i, wb_stb_i, wb_we_i;
  logic [AW+1:0] wb_adr_i;
  logic [3:0]    wb_sel_i;
  logic [31:0]   wb_dat_i, wb_dat_o;
  logic          wb_ack_o, wb_err_o;
  logic [AW-1:0] mem_addr_o;
  logic [31:0]   mem_wr_data_o;
  logic          mem_rd_o, mem_wr_o;
  logic [31:0]   mem_rd_data_i;
  logic          mem_rd_done_i, mem_wr_done_i, mem_rd_error_i, mem_wr_error_i;
  logic          timeout_o;
  logic [7:0]    timeout_count_o;
  state_t        dbg_state;

  logic [4:0] ctl;
  assign ctl = {wb_ack_o, wb_err_o, timeout_o, mem_rd_o, mem_wr_o};

  wb_vmemem_bridge #(.ADDR_WIDTH(AW), .TIMEOUT(TMO)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .wb_cyc_i        (wb_cyc_i),
    .wb_stb_i        (wb_stb_i),
    .wb_we_i         (wb_we_i),
    .wb_adr_i        (wb_adr_i),
    .wb_sel_i        (wb_sel_i),
    .wb_dat_i        (wb_dat_i),
    .wb_dat_o        (wb_dat_o),
    .wb_ack_o        (wb_ack_o),
    .wb_err_o        (wb_err_o),
    .mem_addr_o      (mem_addr_o),
    .mem_wr_data_o   (mem_wr_data_o),
    .mem_rd_o        (mem_rd_o),
    .mem_wr_o        (mem_wr_o),
    .mem_rd_data_i   (mem_rd_data_i),
    .mem_rd_done_i   (mem_rd_done_i),
    .mem_wr_done_i   (mem_wr_done_i),
    .mem_rd_error_i  (mem_rd_error_i),
    .mem_wr_error_i  (mem_wr_error_i),
    .timeout_o       (timeout_o),
    .timeout_count_o (timeout_count_o),
    .dbg_state_o     (dbg_state)
  );

  // ---------------------------------------------------------------- scoreboard
  int          n_total = 0;
  int          n_bad   = 0;
  int          tmo_model = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- drivers
  task automatic bank_quiet();
    mem_rd_done_i  = 1'b0;
    mem_wr_done_i  = 1'b0;
    mem_rd_error_i = 1'b0;
    mem_wr_error_i = 1'b0;
  endtask

  // Idle cycles with random done/error noise on every bank line: all ignored.
  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      wb_cyc_i = 1'b0;
      wb_stb_i = 1'b0;
      mem_rd_done_i  = 1'($urandom_range(0, 1));
      mem_wr_done_i  = 1'($urandom_range(0, 1));
      mem_rd_error_i = 1'($urandom_range(0, 1));
      mem_wr_error_i = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("idle_ctl", 32'(ctl), 32'd0);
      @(posedge clk); #1;
    end
    bank_quiet();
  endtask

  // One Wishbone access, called just after a rising edge (cycle 0).
  // kind: 0 done, 1 error, 2 done+error, 3 silent, 4 wrong-direction pulse.
  // The bank answers 'lat' cycles after the strobe (cycle 1+lat).
  task automatic run_access(input logic we, input logic [AW+1:0] adr,
                            input logic [3:0] sel, input logic [31:0] wdat,
                            input int kind, input int lat, input bit drop,
                            input bit fix_rd, input logic [31:0] rd_val);
    bit          partial, answered, exp_ack, exp_err, exp_tmo, suppress;
    int          res_cyc;
    logic [31:0] d;
    logic [4:0]  exp_ctl;

    partial  = we && (sel != 4'hF);
    answered = !partial && (kind <= 2) && (lat <= TMO);
    if (partial)       res_cyc = 1;
    else if (answered) res_cyc = 2 + lat;
    else               res_cyc = 2 + TMO;
    exp_ack  = answered && (kind != 1);
    exp_err  = !exp_ack;
    exp_tmo  = !partial && !answered;
    suppress = drop && (res_cyc >= 3);

    for (int c = 0; c <= res_cyc; c++) begin
      if (c == 0) begin
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        wb_we_i  = we;
        wb_adr_i = adr;
        wb_sel_i = sel;
        wb_dat_i = wdat;
      end
      if (drop && c >= 2) begin
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
      end
      mem_rd_data_i = $urandom;
      if (we) begin
        mem_wr_done_i  = 1'b0;
        mem_wr_error_i = 1'b0;
        mem_rd_done_i  = 1'($urandom_range(0, 1));
        mem_rd_error_i = 1'($urandom_range(0, 1));
      end else begin
        mem_rd_done_i  = 1'b0;
        mem_rd_error_i = 1'b0;
        mem_wr_done_i  = 1'($urandom_range(0, 1));
        mem_wr_error_i = 1'($urandom_range(0, 1));
      end
      if (!partial && c == 1 + lat) begin
        if (fix_rd) mem_rd_data_i = rd_val;
        case (kind)
          0: if (we) mem_wr_done_i = 1'b1; else mem_rd_done_i = 1'b1;
          1: if (we) mem_wr_error_i = 1'b1; else mem_rd_error_i = 1'b1;
          2: begin
            if (we) begin mem_wr_done_i = 1'b1; mem_wr_error_i = 1'b1; end
            else begin mem_rd_done_i = 1'b1; mem_rd_error_i = 1'b1; end
          end
          4: begin
            if (we) begin mem_rd_done_i = 1'b1; mem_rd_error_i = 1'b1; end
            else begin mem_wr_done_i = 1'b1; mem_wr_error_i = 1'b1; end
          end
          default: ;
        endcase
        if (answered && kind != 1 && !we) exp_q.push_back(mem_rd_data_i);
      end

      @(negedge clk);
      exp_ctl = '0;
      exp_ctl[1] = !partial && !we && (c == 1);
      exp_ctl[0] = !partial && we && (c == 1);
      if (c == res_cyc) begin
        exp_ctl[4] = exp_ack && !suppress;
        exp_ctl[3] = exp_err && !suppress;
        exp_ctl[2] = exp_tmo;
      end
      chk("ctl", 32'(ctl), 32'(exp_ctl));
      if (c == 1) begin
        chk("mem_addr", 32'(mem_addr_o), 32'(adr >> 2));
        chk("mem_wr_data", mem_wr_data_o, wdat);
      end
      if (c == res_cyc) begin
        if (exp_ack && !we) begin
          d = exp_q.pop_front();
          if (!suppress) chk("rd_data", wb_dat_o, d);
        end else if (!suppress) begin
          chk("dat_zero", wb_dat_o, 32'd0);
        end
        if (exp_tmo && tmo_model < 255) tmo_model++;
        chk("tmo_count", 32'(timeout_count_o), 32'(tmo_model));
      end
      @(posedge clk); #1;
    end
    wb_cyc_i = 1'b0;
    wb_stb_i = 1'b0;
    bank_quiet();
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    int          kind, lat, r;
    logic        we, drop;
    logic [3:0]  sel;

    rst_n = 1'b0;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    wb_adr_i = '0; wb_sel_i = 4'h0; wb_dat_i = '0;
    mem_rd_data_i = '0;
    bank_quiet();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ctl", 32'(ctl), 32'd0);
    chk("rst_dat", wb_dat_o, 32'd0);
    chk("rst_addr", 32'(mem_addr_o), 32'd0);
    chk("rst_wdat", mem_wr_data_o, 32'd0);
    chk("rst_tcnt", 32'(timeout_count_o), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'(IDLE));
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle_cycles(2);

    // Directed: read 0x4 -> BEEF, write full word, partial write, timeout,
    // done+error together, wrong-direction only, cyc drop.
    run_access(1'b0, 20'h00004, 4'hF, 32'h0, 0, 1, 1'b0, 1'b1, 32'h0000_BEEF);
    run_access(1'b1, 20'h00000, 4'hF, 32'hA5A5_00FF, 0, 2, 1'b0, 1'b0, 32'h0);
    run_access(1'b1, 20'h00008, 4'h3, 32'h1234_5678, 0, 0, 1'b0, 1'b0, 32'h0);
    run_access(1'b0, 20'h0000C, 4'hF, 32'h0, 3, 0, 1'b0, 1'b0, 32'h0);
    run_access(1'b0, 20'h00010, 4'hF, 32'h0, 2, 1, 1'b0, 1'b0, 32'h0);
    run_access(1'b1, 20'h00014, 4'hF, 32'h5555_AAAA, 4, 1, 1'b0, 1'b0, 32'h0);
    run_access(1'b0, 20'h00018, 4'hF, 32'h0, 0, 0, 1'b0, 1'b0, 32'h0);
    run_access(1'b0, 20'h0001C, 4'hF, 32'h0, 0, 3, 1'b1, 1'b0, 32'h0);
    idle_cycles(3);

    // Reset while an access waits on the bank.
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0;
    wb_adr_i = 20'h00020; wb_sel_i = 4'hF;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    mem_rd_done_i = 1'b1;
    tmo_model = 0;
    @(negedge clk);
    chk("wrst_ctl", 32'(ctl), 32'd0);
    chk("wrst_dat", wb_dat_o, 32'd0);
    chk("wrst_addr", 32'(mem_addr_o), 32'd0);
    chk("wrst_tcnt", 32'(timeout_count_o), 32'd0);
    @(posedge clk); #1;
    mem_rd_done_i = 1'b0;
    @(negedge clk);
    chk("wrst_late_done", 32'(ctl), 32'd0);
    @(posedge clk); #1;

    // Randomized traffic.
    for (int i = 0; i < 150; i++) begin
      we   = 1'($urandom_range(0, 1));
      sel  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
      r    = $urandom_range(0, 9);
      kind = (r < 5) ? 0 : (r < 7) ? 1 : (r == 7) ? 2 : (r == 8) ? 3 : 4;
      lat  = $urandom_range(0, 5);
      drop = ($urandom_range(0, 7) == 0);
      run_access(we, 20'($urandom), sel, $urandom, kind, lat, drop, 1'b0, 32'h0);
      idle_cycles($urandom_range(0, 2));
    end

    // Drive the timeout counter into saturation.
    for (int i = 0; i < 300; i++) begin
      run_access(1'($urandom_range(0, 1)), 20'($urandom), 4'hF, $urandom,
                 3, 0, 1'b0, 1'b0, 32'h0);
    end
    @(negedge clk);
    chk("tcnt_saturated", 32'(timeout_count_o), 32'd255);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/wb_vmemem_bridge.md
Name: wb_vmemem_bridge

Overview:
- Upstream master stage for the generated register banks that use the VME memory-style slave interface (VMEAddr/VMERdMem/VMEWrMem/VMERdDone/VMEWrDone/VMERdError/VMEWrError).
- Converts Wishbone classic single cycles into one-cycle rd/wr strobes, waits for done or error, and returns ack or err.
- Has a per-access timeout so an unresponsive bank can never hang the bus.

Parameters:
ADDR_WIDTH, 18, word-address width driven to the bank (byte address bits [ADDR_WIDTH+1:2]).
TIMEOUT, 255, max WAIT cycles before an error is forced (1..65535).

Ports:
clk  in  1  system clock, all logic on rising edge.
rst_n  in  1  reset; synchronous, active-low.
wb_cyc_i  in  1  Wishbone cycle.
wb_stb_i  in  1  Wishbone strobe.
wb_we_i  in  1  1 = write, 0 = read.
wb_adr_i  in  ADDR_WIDTH+2  byte address; bits [1:0] ignored.
wb_sel_i  in  4  byte selects.
wb_dat_i  in  32  write data.
wb_dat_o  out  32  read data, valid while wb_ack_o=1.
wb_ack_o  out  1  one-cycle completion pulse.
wb_err_o  out  1  one-cycle error pulse.
mem_addr_o  out  ADDR_WIDTH  word address to bank.
mem_wr_data_o  out  32  write data to bank.
mem_rd_o  out  1  one-cycle read strobe.
mem_wr_o  out  1  one-cycle write strobe.
mem_rd_data_i  in  32  bank read data, sampled with mem_rd_done_i.
mem_rd_done_i  in  1  read done.
mem_wr_done_i  in  1  write done.
mem_rd_error_i  in  1  read error.
mem_wr_error_i  in  1  write error.
timeout_o  out  1  one-cycle pulse on each timeout.
timeout_count_o  out  8  saturating count of timeouts since reset.

Behaviour:
- Reset: every output is 0, state IDLE, counters 0. An access in progress at reset is abandoned with no ack or err.
- FSM states: IDLE, WAIT, RESP. All outputs are registered.
- IDLE, on cyc&stb:
  - Latch address and data.
  - If we=1 and sel!=4'hF: go to RESP with err (partial writes are unsupported); no mem strobe is issued.
  - Otherwise: next cycle assert mem_rd_o or mem_wr_o for exactly 1 cycle, enter WAIT, and load the timeout counter with TIMEOUT.
- mem_addr_o and mem_wr_data_o hold the latched values from the strobe cycle until the next access.
- WAIT: only done/error of the matching direction is observed. Sampling starts in the strobe cycle itself, so a combinational done is legal.
  - Done: capture mem_rd_data_i (reads) and go to RESP(ack).
  - Error: go to RESP(err).
  - Neither: decrement the counter. When the counter is 0 with no done: RESP(err), pulse timeout_o, increment timeout_count_o (saturates at 255).
- WAIT priority in the same cycle: done > error > timeout.
- Done/error in IDLE or RESP, or of the wrong direction, is ignored.
- RESP: wb_ack_o or wb_err_o is high for exactly 1 cycle if wb_cyc_i is still 1, otherwise suppressed. wb_dat_o is 0 on writes and errors. Return to IDLE.
- Master drops cyc during WAIT: the bank transaction cannot be cancelled. Stay in WAIT until done/error/timeout, then suppress the response.
- Back-to-back: a request held in the cycle after RESP is accepted.
- Latency: request seen at cycle 0, strobe at cycle 1. With the bank answering L cycles after the strobe, ack arrives at cycle 2+L. Generated banks give L=1 for reads and L=2 for writes, so ack at cycles 3 and 4.
- Unmapped addresses are the bank's concern; the bridge forwards whatever done/error it gets.

Decomposition:
- Package wb_vmemem_pkg:
  - state enum {IDLE, WAIT, RESP};
  - WB_SEL_FULL = 4'hF;
  - timeout counter width function clog2(TIMEOUT+1).
- One natural sub-module: bridge_timeout_ctr (load/decrement/zero flag plus 8-bit saturating event counter).
- FSM and datapath stay in the top level.

Test Plan:
- Read adr 0x00004, bank returns 0x0000_BEEF with done 1 cycle after mem_rd_o -> mem_addr_o=1, mem_rd_o 1-cycle pulse at cycle 1, wb_ack_o at cycle 3, wb_dat_o=0x0000_BEEF.
- Write 0xA5A5_00FF, adr 0, sel=F, wr_done 2 cycles after strobe -> mem_wr_data_o=0xA5A5_00FF, ack at cycle 4, wb_dat_o=0.
- Write with sel=4'h3 -> wb_err_o pulse, mem_wr_o never asserted, timeout_count_o unchanged.
- TIMEOUT=4, bank silent -> err exactly 5 WAIT cycles after the strobe, timeout_o pulse, timeout_count_o=1. Repeat 300 times -> saturates at 255.
- Done and rd_error in the same cycle -> ack, not err. wr_done pulsed while in IDLE -> no ack.
- cyc dropped during WAIT, then done -> no ack/err. rst_n low during WAIT -> IDLE and all outputs 0 the next cycle, a later done is ignored.
